// File: rtl/picosoc_bus_pkg.sv
// Shared types and constants for the PicoRV32 native-bus decoder.
package picosoc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  localparam logic ERR_CAUSE_MISS    = 1'b0;
  localparam logic ERR_CAUSE_TIMEOUT = 1'b1;

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/picosoc_addr_match.sv
// NSLV-way base/mask address comparator; the lowest-index matching region wins.
module picosoc_addr_match
  import picosoc_bus_pkg::*;
#(
  parameter int                 NSLV = 4,
  parameter logic [NSLV*32-1:0] BASE = {NSLV{32'h0}},
  parameter logic [NSLV*32-1:0] MASK = {NSLV{32'hFF00_0000}}
) (
  input  logic [31:0]     i_addr,
  output logic [NSLV-1:0] o_hit,
  output logic            o_miss
);

  logic w_found;

  // Priority scan: once a region has matched, later regions are ignored.
  always_comb begin
    w_found = 1'b0;
    o_hit   = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (!w_found &&
          ((i_addr & MASK[32*i +: 32]) == (BASE[32*i +: 32] & MASK[32*i +: 32]))) begin
        o_hit[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  assign o_miss = ~w_found;

endmodule

// File: rtl/picosoc_bus_decoder.sv
// PicoRV32 native-bus decoder: one CPU port fanned out to NSLV regions, each
// either slave-handshaked (with watchdog) or fixed-latency.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for m_valid; request latched and decoded on accept
// ST_ACCESS | s_valid to the selected slave; wait for ready/latency/timeout
// ST_RESP   | one-cycle m_ready with registered m_rdata
module picosoc_bus_decoder
  import picosoc_bus_pkg::*;
#(
  parameter int                 NSLV      = 4,
  parameter logic [NSLV*32-1:0] BASE      = {NSLV{32'h0}},
  parameter logic [NSLV*32-1:0] MASK      = {NSLV{32'hFF00_0000}},
  parameter logic [NSLV*4-1:0]  LAT       = {NSLV{4'd0}},
  parameter int                 TIMEOUT   = 255,
  parameter logic [31:0]        ERR_RDATA = DEFAULT_ERR_RDATA
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               m_valid,
  input  logic               m_instr,
  input  logic [31:0]        m_addr,
  input  logic [31:0]        m_wdata,
  input  logic [3:0]         m_wstrb,
  output logic               m_ready,
  output logic [31:0]        m_rdata,
  output logic [NSLV-1:0]    s_valid,
  output logic               s_instr,
  output logic [31:0]        s_addr,
  output logic [31:0]        s_wdata,
  output logic [3:0]         s_wstrb,
  input  logic [NSLV-1:0]    s_ready,
  input  logic [NSLV*32-1:0] s_rdata,
  output logic               err_pulse,
  output logic [31:0]        err_addr,
  output logic               err_cause
);

  localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

  bus_state_e       r_state;
  bus_state_e       w_state_nxt;
  logic [NSLV-1:0]  r_sel;
  logic [3:0]       r_lat;
  logic [7:0]       r_cnt;
  logic             r_s_instr;
  logic [31:0]      r_s_addr;
  logic [31:0]      r_s_wdata;
  logic [3:0]       r_s_wstrb;
  logic [31:0]      r_m_rdata;
  logic             r_err_pulse;
  logic [31:0]      r_err_addr;
  logic             r_err_cause;

  logic [NSLV-1:0]  w_hit;
  logic             w_miss;
  logic [3:0]       w_hit_lat;
  logic [31:0]      w_sel_rdata;
  logic             w_sel_ready;
  logic             w_lat_expired;
  logic             w_timeout;

  picosoc_addr_match #(
    .NSLV (NSLV),
    .BASE (BASE),
    .MASK (MASK)
  ) u_match (
    .i_addr (m_addr),
    .o_hit  (w_hit),
    .o_miss (w_miss)
  );

  // Latency setting of the region being decoded in IDLE.
  always_comb begin
    w_hit_lat = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (w_hit[i]) w_hit_lat = LAT[4*i +: 4];
    end
  end

  // Ready/data of the latched slave only; other slaves' ready is ignored.
  always_comb begin
    w_sel_rdata = '0;
    w_sel_ready = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (r_sel[i]) begin
        w_sel_rdata = s_rdata[32*i +: 32];
        w_sel_ready = s_ready[i];
      end
    end
  end

  // Fixed-latency regions drop s_valid after k cycles and respond one cycle
  // later; the watchdog only applies to handshake regions and loses to ready.
  assign w_lat_expired = (r_lat != 4'd0) && (r_cnt >= {4'd0, r_lat});
  assign w_timeout     = (r_lat == 4'd0) && !w_sel_ready && ((r_cnt + 8'd1) == TIMEOUT_C);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (m_valid) w_state_nxt = w_miss ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (r_lat == 4'd0) begin
          if (w_sel_ready || w_timeout) w_state_nxt = ST_RESP;
        end else if (w_lat_expired) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, access counter, response data and error capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sel       <= '0;
      r_lat       <= '0;
      r_cnt       <= '0;
      r_s_instr   <= 1'b0;
      r_s_addr    <= '0;
      r_s_wdata   <= '0;
      r_s_wstrb   <= '0;
      r_m_rdata   <= '0;
      r_err_pulse <= 1'b0;
      r_err_addr  <= '0;
      r_err_cause <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (m_valid) begin
            r_s_instr <= m_instr;
            r_s_addr  <= m_addr;
            r_s_wdata <= m_wdata;
            r_s_wstrb <= m_wstrb;
            r_sel     <= w_hit;
            r_lat     <= w_hit_lat;
            r_cnt     <= '0;
            if (w_miss) begin
              r_m_rdata   <= ERR_RDATA;
              r_err_pulse <= 1'b1;
              r_err_addr  <= m_addr;
              r_err_cause <= ERR_CAUSE_MISS;
            end
          end
        end
        ST_ACCESS: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_lat == 4'd0) begin
            if (w_sel_ready) begin
              r_m_rdata <= w_sel_rdata;
            end else if (w_timeout) begin
              r_m_rdata   <= ERR_RDATA;
              r_err_pulse <= 1'b1;
              r_err_addr  <= r_s_addr;
              r_err_cause <= ERR_CAUSE_TIMEOUT;
            end
          end else if (w_lat_expired) begin
            r_m_rdata <= w_sel_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_valid   = ((r_state == ST_ACCESS) && !w_lat_expired) ? r_sel : '0;
  assign m_ready   = (r_state == ST_RESP);
  assign m_rdata   = r_m_rdata;
  assign s_instr   = r_s_instr;
  assign s_addr    = r_s_addr;
  assign s_wdata   = r_s_wdata;
  assign s_wstrb   = r_s_wstrb;
  assign err_pulse = r_err_pulse;
  assign err_addr  = r_err_addr;
  assign err_cause = r_err_cause;

endmodule

// File: tb/tb_picosoc_bus_decoder.sv
// Directed bench for picosoc_bus_decoder. Inputs change on the falling edge,
// outputs are observed on the falling edge; "cycle n" is the period after the
// n-th rising edge counted from the edge that accepts the request (cycle 0).
module tb_picosoc_bus_decoder;

  localparam logic [127:0] P_BASE = {32'h0800_0000, 32'h0000_0000, 32'h0010_0000, 32'h0000_0000};
  localparam logic [127:0] P_MASK = {32'hFF00_0000, 32'hFF00_0000, 32'hFFF0_0000, 32'hFFF0_0000};
  localparam logic [15:0]  P_LAT  = {4'd3, 4'd0, 4'd1, 4'd0};

  logic         clk;
  logic         resetn;
  logic         m_valid;
  logic         m_instr;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [3:0]   m_wstrb;
  logic         m_ready;
  logic [31:0]  m_rdata;
  logic [3:0]   s_valid;
  logic         s_instr;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wstrb;
  logic [3:0]   s_ready;
  logic [127:0] s_rdata;
  logic         err_pulse;
  logic [31:0]  err_addr;
  logic         err_cause;

  int n_chk;
  int n_err;
  int err_seen;

  picosoc_bus_decoder #(
    .NSLV      (4),
    .BASE      (P_BASE),
    .MASK      (P_MASK),
    .LAT       (P_LAT),
    .TIMEOUT   (8),
    .ERR_RDATA (32'hDEAD_BEEF)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .m_valid   (m_valid),
    .m_instr   (m_instr),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata),
    .s_valid   (s_valid),
    .s_instr   (s_instr),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata),
    .err_pulse (err_pulse),
    .err_addr  (err_addr),
    .err_cause (err_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles in which err_pulse was high.
  always @(posedge clk) if (err_pulse === 1'b1) err_seen <= err_seen + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic req(input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input logic instr);
    m_valid = 1'b1;
    m_addr  = addr;
    m_wdata = wdata;
    m_wstrb = wstrb;
    m_instr = instr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk = 0; n_err = 0; err_seen = 0;
    resetn = 1'b0; m_valid = 1'b0; m_instr = 1'b0; m_addr = '0;
    m_wdata = '0; m_wstrb = '0; s_ready = '0; s_rdata = '0;
    repeat (3) cyc();

    // Reset values
    check("rst_m_ready",   32'(m_ready),   32'd0);
    check("rst_m_rdata",   m_rdata,        32'd0);
    check("rst_s_valid",   32'(s_valid),   32'd0);
    check("rst_s_addr",    s_addr,         32'd0);
    check("rst_s_wdata",   s_wdata,        32'd0);
    check("rst_s_wstrb",   32'(s_wstrb),   32'd0);
    check("rst_s_instr",   32'(s_instr),   32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_err_addr",  err_addr,       32'd0);
    check("rst_err_cause", 32'(err_cause), 32'd0);
    resetn = 1'b1;
    cyc();

    // Handshake read from slave 0, ready at cycle 3; m_addr disturbed mid-access
    req(32'h0000_0040, 32'h0, 4'b0000, 1'b1);
    cyc();
    check("t1_c1_s_valid", 32'(s_valid), 32'h1);
    check("t1_c1_s_addr",  s_addr,       32'h0000_0040);
    check("t1_c1_s_instr", 32'(s_instr), 32'h1);
    check("t1_c1_m_ready", 32'(m_ready), 32'h0);
    m_addr = 32'hFFFF_FFFF; m_instr = 1'b0;
    cyc();
    check("t1_c2_s_addr_hold",  s_addr,       32'h0000_0040);
    check("t1_c2_s_instr_hold", 32'(s_instr), 32'h1);
    check("t1_c2_s_valid",      32'(s_valid), 32'h1);
    s_ready = 4'b0010; s_rdata[63:32] = 32'h1111_1111;
    cyc();
    check("t1_c3_foreign_ready_s_valid", 32'(s_valid), 32'h1);
    check("t1_c3_foreign_ready_m_ready", 32'(m_ready), 32'h0);
    s_ready = 4'b0001; s_rdata[31:0] = 32'h1234_5678;
    cyc();
    check("t1_c4_m_ready", 32'(m_ready), 32'h1);
    check("t1_c4_m_rdata", m_rdata,      32'h1234_5678);
    check("t1_c4_s_valid", 32'(s_valid), 32'h0);
    m_valid = 1'b0; s_ready = '0;
    cyc();
    check("t1_c5_m_ready_one_cycle", 32'(m_ready), 32'h0);
    check("t1_no_err_pulse",         32'(err_seen), 32'd0);

    // Write to LAT=1 region
    req(32'h0010_0000, 32'hA5A5_0011, 4'b0011, 1'b0);
    s_rdata[63:32] = 32'h0BAD_F00D;
    cyc();
    check("t2_c1_s_valid", 32'(s_valid), 32'h2);
    check("t2_c1_s_wstrb", 32'(s_wstrb), 32'h3);
    check("t2_c1_s_wdata", s_wdata,      32'hA5A5_0011);
    check("t2_c1_m_ready", 32'(m_ready), 32'h0);
    cyc();
    check("t2_c2_s_valid", 32'(s_valid), 32'h0);
    check("t2_c2_m_ready", 32'(m_ready), 32'h0);
    cyc();
    check("t2_c3_m_ready", 32'(m_ready), 32'h1);
    check("t2_c3_m_rdata", m_rdata,      32'h0BAD_F00D);
    m_valid = 1'b0;
    cyc();

    // Decode miss
    req(32'h0700_0000, 32'h0, 4'b0000, 1'b0);
    cyc();
    check("t3_c1_m_ready",   32'(m_ready),   32'h1);
    check("t3_c1_m_rdata",   m_rdata,        32'hDEAD_BEEF);
    check("t3_c1_err_pulse", 32'(err_pulse), 32'h1);
    check("t3_c1_err_addr",  err_addr,       32'h0700_0000);
    check("t3_c1_err_cause", 32'(err_cause), 32'h0);
    check("t3_c1_s_valid",   32'(s_valid),   32'h0);
    m_valid = 1'b0;
    cyc();
    check("t3_c2_m_ready",   32'(m_ready),   32'h0);
    check("t3_c2_err_pulse", 32'(err_pulse), 32'h0);
    check("t3_err_count",    32'(err_seen),  32'd1);

    // Handshake slave never ready, TIMEOUT=8
    req(32'h0030_0000, 32'h0, 4'b0000, 1'b0);
    for (int n = 1; n <= 8; n++) begin
      cyc();
      check($sformatf("t4_c%0d_s_valid", n), 32'(s_valid), 32'h4);
      check($sformatf("t4_c%0d_m_ready", n), 32'(m_ready), 32'h0);
    end
    cyc();
    check("t4_c9_m_ready",   32'(m_ready),   32'h1);
    check("t4_c9_err_pulse", 32'(err_pulse), 32'h1);
    check("t4_c9_err_cause", 32'(err_cause), 32'h1);
    check("t4_c9_m_rdata",   m_rdata,        32'hDEAD_BEEF);
    check("t4_c9_err_addr",  err_addr,       32'h0030_0000);
    check("t4_c9_s_valid",   32'(s_valid),   32'h0);
    m_valid = 1'b0;
    cyc();
    check("t4_err_count", 32'(err_seen), 32'd2);

    // Ready arriving in the cycle the counter reaches TIMEOUT is a success
    req(32'h0030_0004, 32'h0, 4'b0000, 1'b0);
    repeat (8) cyc();
    check("t4b_c8_s_valid", 32'(s_valid), 32'h4);
    s_ready = 4'b0100; s_rdata[95:64] = 32'h600D_0008;
    cyc();
    check("t4b_c9_m_ready",   32'(m_ready),   32'h1);
    check("t4b_c9_m_rdata",   m_rdata,        32'h600D_0008);
    check("t4b_c9_err_pulse", 32'(err_pulse), 32'h0);
    m_valid = 1'b0; s_ready = '0;
    cyc();

    // Fixed latency k=3: s_valid cycles 1..3, m_ready at cycle 5
    req(32'h0800_0010, 32'h0, 4'b0000, 1'b0);
    s_rdata[127:96] = 32'h3333_0003;
    cyc();
    check("t7_c1_s_valid", 32'(s_valid), 32'h8);
    cyc();
    cyc();
    check("t7_c3_s_valid", 32'(s_valid), 32'h8);
    cyc();
    check("t7_c4_s_valid", 32'(s_valid), 32'h0);
    check("t7_c4_m_ready", 32'(m_ready), 32'h0);
    cyc();
    check("t7_c5_m_ready", 32'(m_ready), 32'h1);
    check("t7_c5_m_rdata", m_rdata,      32'h3333_0003);
    m_valid = 1'b0;
    cyc();

    // Overlap of regions 0 and 2: region 0 wins; region 2 alone elsewhere
    req(32'h000F_FFFC, 32'h0, 4'b0000, 1'b0);
    cyc();
    check("t5_overlap_s_valid", 32'(s_valid), 32'h1);
    s_ready = 4'b0001; s_rdata[31:0] = 32'h0F0F_0F0F;
    cyc();
    check("t5_overlap_m_ready", 32'(m_ready), 32'h1);
    check("t5_overlap_m_rdata", m_rdata,      32'h0F0F_0F0F);
    m_valid = 1'b0; s_ready = '0;
    cyc();
    req(32'h0020_0000, 32'h0, 4'b0000, 1'b0);
    cyc();
    check("t5_r2_s_valid", 32'(s_valid), 32'h4);
    s_ready = 4'b0100; s_rdata[95:64] = 32'h2020_2020;
    cyc();
    check("t5_r2_m_ready", 32'(m_ready), 32'h1);
    check("t5_r2_m_rdata", m_rdata,      32'h2020_2020);
    m_valid = 1'b0; s_ready = '0;
    cyc();
    check("t5_err_count", 32'(err_seen), 32'd2);

    // Reset asserted mid-ACCESS, then a fresh read
    req(32'h0000_0080, 32'h0, 4'b0000, 1'b0);
    cyc();
    check("t6_c1_s_valid", 32'(s_valid), 32'h1);
    cyc();
    resetn = 1'b0;
    #1;
    check("t6_rst_s_valid",  32'(s_valid), 32'h0);
    check("t6_rst_m_ready",  32'(m_ready), 32'h0);
    check("t6_rst_err_addr", err_addr,     32'h0);
    check("t6_rst_s_addr",   s_addr,       32'h0);
    m_valid = 1'b0;
    cyc();
    resetn = 1'b1;
    cyc();
    cyc();
    check("t6_no_resp_m_ready", 32'(m_ready), 32'h0);
    check("t6_no_resp_s_valid", 32'(s_valid), 32'h0);
    req(32'h0000_0084, 32'h0, 4'b0000, 1'b0);
    cyc();
    check("t6_new_s_valid", 32'(s_valid), 32'h1);
    check("t6_new_s_addr",  s_addr,       32'h0000_0084);
    s_ready = 4'b0001; s_rdata[31:0] = 32'h5A5A_0084;
    cyc();
    check("t6_new_m_ready", 32'(m_ready), 32'h1);
    check("t6_new_m_rdata", m_rdata,      32'h5A5A_0084);
    m_valid = 1'b0; s_ready = '0;
    cyc();
    check("t6_new_m_ready_drop", 32'(m_ready), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/picosoc_bus_decoder.md
# picosoc_bus_decoder

Parametrised PicoRV32 native-bus decoder/arbiter that fans one CPU memory port out to NSLV slave regions. Each region has a base/mask match and either a slave-driven handshake or a fixed internal latency, with a watchdog timeout and error capture for unmapped or hung accesses. It sits between the picorv32 core and the SoC memories/peripherals, replacing hand-written ready/rdata muxing in SoC top levels.

## Interface
- NSLV, 4: number of slave regions (1..8).
- BASE, {NSLV{32'h0}}: packed NSLV×32 region base addresses; slot i at [32*i +: 32].
- MASK, {NSLV{32'hFF00_0000}}: packed NSLV×32 compare masks; region i hits when (addr & MASK_i) == (BASE_i & MASK_i).
- LAT, {NSLV{4'd0}}: packed NSLV×4 fixed latency; 0 means wait for s_ready[i], k>0 means respond k cycles after s_valid rises, ignoring s_ready[i].
- TIMEOUT, 255: cycles of s_valid without s_ready before abort (8-bit counter, 1..255).
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on error.
- clk  in  1  system clock
- resetn  in  1  reset; asynchronous, active-low
- m_valid  in  1  CPU request valid
- m_instr  in  1  instruction fetch flag (forwarded)
- m_addr  in  32  CPU address
- m_wdata  in  32  CPU write data
- m_wstrb  in  4  byte strobes; 0 = read
- m_ready  out  1  one-cycle response pulse
- m_rdata  out  32  registered read data, valid with m_ready
- s_valid  out  NSLV  one-hot slave select
- s_instr, s_addr, s_wdata, s_wstrb  out  1/32/32/4  latched request, broadcast to all slaves
- s_ready  in  NSLV  per-slave ready
- s_rdata  in  NSLV×32  packed slave read data
- err_pulse  out  1  one-cycle pulse on decode miss or timeout
- err_addr  out  32  address of most recent error
- err_cause  out  1  0 = decode miss, 1 = timeout

## Operation
- FSM: IDLE, ACCESS, RESP.
- IDLE: on m_valid, latch addr/wdata/wstrb/instr; decode. Lowest-index hit wins on overlap. Hit → ACCESS with s_valid[i]=1, counter cleared. Miss → RESP with rdata=ERR_RDATA, err_pulse, err_cause=0, err_addr latched; no slave sees the access, writes dropped.
- ACCESS, LAT_i=0: on s_ready[i], capture s_rdata[i], drop s_valid, → RESP. Counter increments each cycle; when it equals TIMEOUT without ready → RESP with ERR_RDATA, err_pulse, err_cause=1, s_valid dropped.
- ACCESS, LAT_i=k: after k cycles of s_valid, capture s_rdata[i], → RESP. No timeout.
- RESP: m_ready=1 for exactly one cycle with m_rdata; → IDLE. m_valid is not sampled in RESP.
- Reads and writes are handled identically; m_rdata for writes is the captured (don't-care) data.
- Request fields are held stable on s_* for the whole ACCESS state even if m_* changes.

## Timing
- Reset values: m_ready=0, m_rdata=0, s_valid=0, s_addr/s_wdata/s_wstrb/s_instr=0, err_pulse=0, err_addr=0, err_cause=0, FSM=IDLE, counter=0.
- Request seen in IDLE at cycle 0 → s_valid high from cycle 1.
- Handshake slave: s_ready sampled at cycle n≥1 → m_ready at cycle n+1. Minimum 3 cycles per access.
- Fixed latency k: m_ready at cycle k+2.
- Decode miss: m_ready and err_pulse at cycle 1.
- Timeout: s_valid high cycles 1..TIMEOUT; m_ready and err_pulse at cycle TIMEOUT+1.
- s_ready from a non-selected slave is ignored. s_ready in the same cycle the counter reaches TIMEOUT counts as success.
- resetn low at any time (incl. ACCESS) drops s_valid and m_ready asynchronously; the aborted access gets no response.

## Structure
- Package picosoc_bus_pkg: FSM state enum, ERR_CAUSE_MISS/ERR_CAUSE_TIMEOUT constants, default ERR_RDATA.
- Sub-module picosoc_addr_match: combinational NSLV-way base/mask comparator with priority encoder; outputs one-hot hit and a miss flag.

## Test plan
- Read handshake slave 0 (BASE 0x0000_0000, LAT 0), s_ready at cycle 3 with 0x1234_5678 → m_ready at cycle 4, m_rdata=0x1234_5678, err_pulse never.
- Write to LAT=1 region at 0x0010_0000, wstrb=4'b0011 → s_valid[1] at cycle 1 only, s_wstrb=0011, m_ready at cycle 3.
- Access 0x0700_0000 with no matching region → m_ready at cycle 1, m_rdata=0xDEAD_BEEF, err_addr=0x0700_0000, err_cause=0, no s_valid.
- Handshake slave never ready, TIMEOUT=8 → s_valid high cycles 1..8, m_ready and err_pulse at cycle 9, err_cause=1.
- Overlapping regions 0 and 2 both match → only s_valid[0] asserted.
- resetn pulled low at cycle 2 of an ACCESS → s_valid and m_ready 0 immediately; after release, a new read completes normally.
